ysyx_22050612_wb_scheduler: RTL and testbench

Writeback scheduler and scoreboard for the integer register file. It shares the register file's single write port between two writeback requesters, the EXU and the LSU, using round-robin arbitration. It also tracks in-flight destination registers in a busy scoreboard and stalls instruction issue on RAW and WAW hazards. It sits between IDU/EXU/LSU and the register file, and drives the register file's `wen`/`waddr`/`wdata`.

---
 rtl/ysyx_22050612_pkg.sv | 13 +
 rtl/ysyx_22050612_rr_arb2.sv | 36 +++
 rtl/ysyx_22050612_wb_scheduler.sv | 114 +++++++++++
 tb/tb_ysyx_22050612_wb_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050612_pkg.sv
// Shared constants for the writeback scheduler slice.
//   WB_EXU / WB_LSU  : requester indices into the arbiter req/gnt vectors
//   DEF_ADDR_WIDTH   : default register index width
//   DEF_DATA_WIDTH   : default writeback data width
package ysyx_22050612_pkg;

   localparam logic WB_EXU = 1'b0;
   localparam logic WB_LSU = 1'b1;

   localparam int DEF_ADDR_WIDTH = 5;
   localparam int DEF_DATA_WIDTH = 64;

endpackage

// File: rtl/ysyx_22050612_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, async active-high reset
//   req[1:0] : requests, indexed by WB_EXU / WB_LSU
//   gnt[1:0] : one-hot (or zero) grant, combinational from req and last
//
// last | meaning
// -----+--------------------------------------------
// EXU  | EXU was granted most recently, LSU wins tie
// LSU  | LSU was granted most recently, EXU wins tie
module ysyx_22050612_rr_arb2
   import ysyx_22050612_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last;

   always_comb begin
      gnt         = 2'b00;
      gnt[WB_EXU] = req[WB_EXU] && (!req[WB_LSU] || (last == WB_LSU));
      gnt[WB_LSU] = req[WB_LSU] && (!req[WB_EXU] || (last == WB_EXU));
   end

   // Reset to LSU so that EXU takes the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= WB_LSU;
      end else if (|gnt) begin
         last <= gnt[WB_LSU] ? WB_LSU : WB_EXU;
      end
   end

endmodule

// File: rtl/ysyx_22050612_wb_scheduler.sv
// Writeback scheduler and busy scoreboard for the integer register file.
//   issue_*        : IDU instruction presented; issue_ready stalls on RAW/WAW
//   exu_* / lsu_*  : writeback requesters, granted round-robin
//   rf_*           : registered write port into the register file
//   idle           : no busy registers and no write in progress
//   err            : sticky, set by a writeback to a register that is not busy
module ysyx_22050612_wb_scheduler
   import ysyx_22050612_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid,
   input  logic                  issue_wen,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   input  logic [ADDR_WIDTH-1:0] issue_rs1,
   input  logic [ADDR_WIDTH-1:0] issue_rs2,
   output logic                  issue_ready,
   input  logic                  exu_valid,
   input  logic [ADDR_WIDTH-1:0] exu_rd,
   input  logic [DATA_WIDTH-1:0] exu_data,
   output logic                  exu_ready,
   input  logic                  lsu_valid,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   output logic                  lsu_ready,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  idle,
   output logic                  err
);

   localparam int NREG = 1 << ADDR_WIDTH;

   logic [NREG-1:0]       busy;
   logic [NREG-1:0]       busy_set;
   logic [NREG-1:0]       busy_clr;
   logic [NREG-1:0]       busy_nxt;
   logic [1:0]            req;
   logic [1:0]            gnt;
   logic                  any_gnt;
   logic [ADDR_WIDTH-1:0] gnt_rd;
   logic [DATA_WIDTH-1:0] gnt_data;
   logic                  issue_acc;

   assign req[WB_EXU] = exu_valid;
   assign req[WB_LSU] = lsu_valid;

   ysyx_22050612_rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req (req),
      .gnt (gnt)
   );

   assign exu_ready = gnt[WB_EXU];
   assign lsu_ready = gnt[WB_LSU];
   assign any_gnt   = |gnt;
   assign gnt_rd    = gnt[WB_LSU] ? lsu_rd   : exu_rd;
   assign gnt_data  = gnt[WB_LSU] ? lsu_data : exu_data;

   // Deliberately independent of issue_valid so there is no valid->ready path.
   assign issue_ready = !busy[issue_rs1] && !busy[issue_rs2] && !(issue_wen && busy[issue_rd]);
   assign issue_acc   = issue_valid && issue_ready && issue_wen && (issue_rd != '0);

   // Clear follows the registered write so a dependent issue lines up with the
   // register-file update. Set is applied after clear so it wins a collision.
   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      busy_set[issue_rd] = issue_acc;
      busy_clr[rf_waddr] = rf_wen;
      busy_nxt    = (busy & ~busy_clr) | busy_set;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   // Address/data only move on a grant; a grant to x0 still updates them but
   // leaves rf_wen low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_wen <= any_gnt && (gnt_rd != '0);
         if (any_gnt) begin
            rf_waddr <= gnt_rd;
            rf_wdata <= gnt_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (any_gnt && (gnt_rd != '0) && !busy[gnt_rd]) begin
         err <= 1'b1;
      end
   end

   assign idle = !(|busy) && !rf_wen;

endmodule

// File: tb/tb_ysyx_22050612_wb_scheduler.sv
module tb_ysyx_22050612_wb_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid, issue_wen, issue_ready;
   logic [4:0]  issue_rd, issue_rs1, issue_rs2;
   logic        exu_valid, exu_ready, lsu_valid, lsu_ready;
   logic [4:0]  exu_rd, lsu_rd;
   logic [63:0] exu_data, lsu_data;
   logic        rf_wen, idle, err;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ysyx_22050612_wb_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_wen   (issue_wen),
      .issue_rd    (issue_rd),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
      .issue_ready (issue_ready),
      .exu_valid   (exu_valid),
      .exu_rd      (exu_rd),
      .exu_data    (exu_data),
      .exu_ready   (exu_ready),
      .lsu_valid   (lsu_valid),
      .lsu_rd      (lsu_rd),
      .lsu_data    (lsu_data),
      .lsu_ready   (lsu_ready),
      .rf_wen      (rf_wen),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .idle        (idle),
      .err         (err)
   );

   typedef struct {
      logic        iv, iw;
      logic [4:0]  rd, rs1, rs2;
      logic        ev;
      logic [4:0]  erd;
      logic [63:0] ed;
      logic        lv;
      logic [4:0]  lrd;
      logic [63:0] ld;
      logic        x_ir, x_er, x_lr;
      logic        x_wen;
      logic [4:0]  x_waddr;
      logic [63:0] x_wdata;
      logic        x_err, x_idle;
   } vec_t;

   vec_t tv [19];

   function automatic vec_t mk(
      input logic iv, iw, input logic [4:0] rd, rs1, rs2,
      input logic ev, input logic [4:0] erd, input logic [63:0] ed,
      input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
      input logic x_ir, x_er, x_lr,
      input logic x_wen, input logic [4:0] x_waddr, input logic [63:0] x_wdata,
      input logic x_err, x_idle);
      vec_t v;
      v.iv = iv; v.iw = iw; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.ev = ev; v.erd = erd; v.ed = ed;
      v.lv = lv; v.lrd = lrd; v.ld = ld;
      v.x_ir = x_ir; v.x_er = x_er; v.x_lr = x_lr;
      v.x_wen = x_wen; v.x_waddr = x_waddr; v.x_wdata = x_wdata;
      v.x_err = x_err; v.x_idle = x_idle;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      issue_valid = 0; issue_wen = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
      exu_valid = 0; exu_rd = 0; exu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
   endtask

   // Each step leaves time at posedge+2.
   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   initial begin
      //                 iv iw rd rs1 rs2  ev erd ed        lv lrd ld       ir er lr  wen wa wdata     err idle
      tv[0]  = mk(0, 1, 9, 10, 31, 0, 0, 0,        0, 0, 0,       1, 0, 0, 0, 0, 0,        0, 1);
      tv[1]  = mk(1, 1, 5, 1,  2,  0, 0, 0,        0, 0, 0,       1, 0, 0, 0, 0, 0,        0, 0);
      tv[2]  = mk(1, 1, 6, 5,  0,  0, 0, 0,        0, 0, 0,       0, 0, 0, 0, 0, 0,        0, 0);
      tv[3]  = mk(1, 1, 6, 5,  0,  1, 5, 64'h1234, 0, 0, 0,       0, 1, 0, 1, 5, 64'h1234, 0, 0);
      tv[4]  = mk(1, 1, 6, 5,  0,  0, 0, 0,        0, 0, 0,       0, 0, 0, 0, 5, 64'h1234, 0, 1);
      tv[5]  = mk(1, 1, 6, 5,  0,  0, 0, 0,        0, 0, 0,       1, 0, 0, 0, 5, 64'h1234, 0, 0);
      tv[6]  = mk(1, 1, 7, 0,  0,  0, 0, 0,        0, 0, 0,       1, 0, 0, 0, 5, 64'h1234, 0, 0);
      tv[7]  = mk(0, 0, 0, 0,  0,  1, 6, 64'hA,    1, 7, 64'hB,   1, 0, 1, 1, 7, 64'hB,    0, 0);
      tv[8]  = mk(0, 0, 0, 0,  0,  1, 6, 64'hA,    1, 0, 64'hC,   1, 1, 0, 1, 6, 64'hA,    0, 0);
      tv[9]  = mk(0, 0, 0, 0,  0,  1, 0, 64'hD,    1, 0, 64'hC,   1, 0, 1, 0, 0, 64'hC,    0, 1);
      tv[10] = mk(0, 0, 0, 0,  0,  1, 0, 64'hD,    1, 0, 64'hE,   1, 1, 0, 0, 0, 64'hD,    0, 1);
      tv[11] = mk(1, 1, 0, 0,  0,  0, 0, 0,        0, 0, 0,       1, 0, 0, 0, 0, 64'hD,    0, 1);
      tv[12] = mk(1, 1, 3, 0,  0,  0, 0, 0,        0, 0, 0,       1, 0, 0, 0, 0, 64'hD,    0, 0);
      tv[13] = mk(1, 1, 3, 0,  0,  0, 0, 0,        0, 0, 0,       0, 0, 0, 0, 0, 64'hD,    0, 0);
      tv[14] = mk(1, 1, 3, 0,  0,  1, 3, 64'h33,   0, 0, 0,       0, 1, 0, 1, 3, 64'h33,   0, 0);
      tv[15] = mk(1, 1, 3, 0,  0,  0, 0, 0,        0, 0, 0,       0, 0, 0, 0, 3, 64'h33,   0, 1);
      tv[16] = mk(1, 1, 3, 0,  0,  0, 0, 0,        0, 0, 0,       1, 0, 0, 0, 3, 64'h33,   0, 0);
      tv[17] = mk(0, 0, 0, 0,  0,  0, 0, 0,        1, 7, 64'h77,  1, 0, 1, 1, 7, 64'h77,   1, 0);
      tv[18] = mk(0, 0, 0, 0,  0,  0, 0, 0,        0, 0, 0,       1, 0, 0, 0, 7, 64'h77,   1, 0);

      clear_inputs();
      rst = 1'b1;
      #2;
      reset_pulse();

      chk("reset idle", idle, 1);
      chk("reset rf_wen", rf_wen, 0);
      chk("reset err", err, 0);
      chk("reset rf_waddr", rf_waddr, 0);
      chk("reset rf_wdata", rf_wdata, 0);
      issue_wen = 1; issue_rd = 31; issue_rs1 = 17; issue_rs2 = 1;
      #1;
      chk("reset issue_ready", issue_ready, 1);
      clear_inputs();
      next_cycle();

      for (int i = 0; i < 19; i++) begin
         issue_valid = tv[i].iv; issue_wen = tv[i].iw; issue_rd = tv[i].rd;
         issue_rs1 = tv[i].rs1; issue_rs2 = tv[i].rs2;
         exu_valid = tv[i].ev; exu_rd = tv[i].erd; exu_data = tv[i].ed;
         lsu_valid = tv[i].lv; lsu_rd = tv[i].lrd; lsu_data = tv[i].ld;
         #1;
         chk($sformatf("v%0d issue_ready", i), issue_ready, tv[i].x_ir);
         chk($sformatf("v%0d exu_ready", i), exu_ready, tv[i].x_er);
         chk($sformatf("v%0d lsu_ready", i), lsu_ready, tv[i].x_lr);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d rf_wen", i), rf_wen, tv[i].x_wen);
         chk($sformatf("v%0d rf_waddr", i), rf_waddr, tv[i].x_waddr);
         chk($sformatf("v%0d rf_wdata", i), rf_wdata, tv[i].x_wdata);
         chk($sformatf("v%0d err", i), err, tv[i].x_err);
         chk($sformatf("v%0d idle", i), idle, tv[i].x_idle);
         #1;
      end
      clear_inputs();

      // err stays set over idle cycles, then clears only on reset.
      next_cycle();
      next_cycle();
      chk("err sticky", err, 1);
      reset_pulse();
      chk("err after rst", err, 0);
      chk("idle after rst", idle, 1);

      // Fresh-reset contention: EXU takes the first tie, then strict alternation.
      exu_valid = 1; exu_rd = 0; lsu_valid = 1; lsu_rd = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("contend%0d exu_ready", i), exu_ready, (i % 2) == 0);
         chk($sformatf("contend%0d lsu_ready", i), lsu_ready, (i % 2) == 1);
         @(posedge clk);
         #1;
      end
      clear_inputs();
      next_cycle();

      // Reset while a write to x4 is in flight.
      issue_valid = 1; issue_wen = 1; issue_rd = 4;
      next_cycle();
      clear_inputs();
      issue_rs1 = 4;
      #1;
      chk("flight busy4 stall", issue_ready, 0);
      exu_valid = 1; exu_rd = 4; exu_data = 64'h44;
      #1;
      chk("flight exu_ready", exu_ready, 1);
      @(posedge clk);
      #2;
      chk("flight rf_wen pre", rf_wen, 1);
      chk("flight rf_waddr pre", rf_waddr, 4);
      exu_valid = 0;
      rst = 1'b1;
      #1;
      chk("flight rst rf_wen", rf_wen, 0);
      chk("flight rst idle", idle, 1);
      chk("flight rst rf_waddr", rf_waddr, 0);
      chk("flight rst issue_ready", issue_ready, 1);
      next_cycle();
      rst = 1'b0;
      next_cycle();
      chk("flight post rf_wen", rf_wen, 0);
      chk("flight post rf_wdata", rf_wdata, 0);
      next_cycle();
      chk("flight post2 rf_wen", rf_wen, 0);
      chk("flight post2 idle", idle, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
